ov7670_pixel_capture: RTL and testbench
=======================================

// Module: ov7670_pixel_capture
// PURPOSE
//  Parametrised camera pixel capture: oversamples OV7670 PCLK/HREF/VSYNC/D on system clk, assembles
//  bytes into pixels (RGB444, RGB565 or RAW8), tags frame/line starts, buffers in a FWFT FIFO with
//  valid/ready output. Sits between camera pins and downstream demosaic/VGA/frame-buffer logic.
// PARAMETERS
//  SYNC_STAGES  2    flops per input synchroniser (>=2)
//  FIFO_DEPTH   16   output FIFO entries, power of 2, >=4
//  CNT_W        11   width of pixel/line counters (640/480 fit)
// PORTS
//  clk           in   1      system clock (100 MHz); cam_pclk must be <= clk/4
//  reset_        in   1      synchronous, active-low reset
//  enable        in   1      capture enable; low forces S_WAIT next cycle
//  mode          in   2      0=RGB444, 1=RGB565, 2/3=RAW8; latched at frame start
//  clr_overflow  in   1      one-cycle pulse clears overflow and line_err
//  cam_pclk      in   1      camera pixel clock (async)
//  cam_href      in   1      line valid, active high (async)
//  cam_vsync     in   1      frame blank, active high (async)
//  cam_d         in   8      camera data (async)
//  pix_data      out  16     pixel: RGB444 {4'h0,R4,G4,B4}; RGB565 {R5,G6,B5}; RAW8 {8'h0,byte}
//  pix_sof       out  1      pixel is first of frame
//  pix_sol       out  1      pixel is first of line
//  pix_valid     out  1      FIFO non-empty
//  pix_ready     in   1      downstream accept; pop when pix_valid&&pix_ready
//  frame_count   out  16     completed frames, wraps
//  line_width    out  CNT_W  pixels in last completed line (saturating)
//  line_count    out  CNT_W  lines in last completed frame (saturating)
//  overflow      out  1      sticky: pixel dropped on full FIFO
//  line_err      out  1      sticky: line ended on odd byte in 2-byte mode
//  busy          out  1      state != S_WAIT
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state S_WAIT, byte_phase 0, counters 0.
//  - cam_* each pass SYNC_STAGES flops; strobe = rising edge of synced PCLK (one clk pulse);
//    synced HREF/VSYNC/D sampled in strobe cycle. All FSM/counter updates only on strobe, except enable.
//  - FSM: S_WAIT -> S_FRAME on synced VSYNC falling edge (latch mode, y=0, first_px=1).
//    S_FRAME -> S_LINE on strobe with HREF=1 (capture that byte, x=0). S_LINE -> S_FRAME on strobe
//    with HREF=0: line_width<=x, y++ (sat). Any state -> S_WAIT on VSYNC rising: if y>0, frame_count++,
//    line_count<=y. enable=0 -> S_WAIT, partial line/frame discarded, stats not updated.
//  - Packing: RAW8 pushes every byte. 2-byte modes: phase0 holds byte, phase1 pushes; RGB444 uses
//    byte0[3:0]=R, byte1={G,B}; RGB565 = {byte0,byte1}. HREF falls with phase=1: drop byte, set line_err.
//  - Push carries sof=(first pixel after frame start), sol=(x==0); x++ (sat) per pushed pixel.
//  - Latency: pix_valid asserts exactly 1 clk after the push cycle (FIFO empty case).
//  - FIFO full on push: pixel dropped, overflow<=1, x still increments. Simultaneous push+pop on full:
//    pop frees slot, push accepted. Simultaneous push+pop on empty: push written, valid next cycle.
//  - clr_overflow coincident with new drop: set wins. mode change mid-frame ignored until next frame.
//  - pix_* stable while pix_valid && !pix_ready. Reset mid-frame: FIFO flushed, back to S_WAIT.
// STRUCTURE
//  - ov7670_pkg: capture_mode_e (MODE_RGB444/RGB565/RAW8), cap_state_e (S_WAIT/S_FRAME/S_LINE),
//    pixel record struct {data[15:0], sof, sol}.
//  - Sub-module sync_fifo #(WIDTH,DEPTH): FWFT, synchronous active-low reset, full/empty, count.
//  - Top body: synchronisers, edge detect, FSM, packer, stats counters.
// TESTING
//  1. RGB565, 4 lines x 4 px, bytes 0xF8,0x1F per pixel, ready=1 -> 16 pixels 0xF81F, first sof=1,
//     4 sol, line_width=4, line_count=4, frame_count=1.
//  2. RGB444, bytes 0x0A,0x5C -> pix_data=0x0A5C; RAW8 line 0x10..0x13 -> 4 pixels 0x0010..0x0013.
//  3. pix_ready=0, 20 pixels with FIFO_DEPTH=16 -> 16 held, overflow=1, pixels 17-20 lost;
//     clr_overflow -> overflow=0; drain order intact.
//  4. 2-byte mode, line of 7 bytes -> 3 pixels pushed, line_err=1, line_width=3.
//  5. enable dropped mid-line then VSYNC rise -> frame_count unchanged, busy=0 next cycle.
//  6. mode toggled 0->1 mid-frame -> current frame stays RGB444, next frame RGB565; reset_=0 mid-line
//     -> pix_valid=0 and all stats 0 the following cycle.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types for the OV7670 capture block: capture modes, FSM states and the FIFO pixel record.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package ov7670_pkg;

  typedef enum logic [1:0] {
    MODE_RGB444 = 2'd0,
    MODE_RGB565 = 2'd1,
    MODE_RAW8   = 2'd2
  } capture_mode_e;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FRAME = 2'd1,
    S_LINE  = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        sol;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

  // Encodings 2 and 3 both mean RAW8.
  function automatic capture_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_RGB444;
      2'd1:    return MODE_RGB565;
      default: return MODE_RAW8;
    endcase
  endfunction

  // Combine the two bytes of a 2-byte pixel. RGB444 keeps only the low nibble of the
  // first byte (R) and the whole second byte ({G,B}).
  function automatic logic [15:0] pack_pair(input capture_mode_e m,
                                            input logic [7:0]    b0,
                                            input logic [7:0]    b1);
    if (m == MODE_RGB444) return {4'h0, b0[3:0], b1};
    else                  return {b0, b1};
  endfunction

endpackage

// File: rtl/ov7670_pixel_capture_sync_fifo.sv
// First-word-fall-through synchronous FIFO used as the pixel output buffer.
// Latency: a write is visible on rd_dat_o / !empty_o one clk after the write cycle.
// Backpressure: writes when full are ignored unless a read happens in the same cycle.
// Ports: wr_en_i/wr_dat_i write side; rd_en_i pops head; rd_dat_o head; full_o/empty_o/count_o status.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_dat_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_rd, do_wr;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == FULL_CNT);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed behind a non-zero count.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 pixel capture: oversample camera pins, pack bytes into RGB444/RGB565/RAW8 pixels, tag sof/sol, buffer in FIFO.
// Latency: SYNC_STAGES+1 clk from PCLK rise to push; pix_valid one clk after the push.
// Backpressure: pix_valid/pix_ready; when the FIFO is full new pixels are dropped and overflow is set.
// Ports: clk/reset_ (sync, active-low); enable, mode, clr_overflow controls; cam_* async camera pins;
//        pix_* stream out; frame_count/line_width/line_count stats; overflow/line_err sticky flags; busy.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             clr_overflow,
  input  logic             cam_pclk,
  input  logic             cam_href,
  input  logic             cam_vsync,
  input  logic [7:0]       cam_d,
  output logic [15:0]      pix_data,
  output logic             pix_sof,
  output logic             pix_sol,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [15:0]      frame_count,
  output logic [CNT_W-1:0] line_width,
  output logic [CNT_W-1:0] line_count,
  output logic             overflow,
  output logic             line_err,
  output logic             busy
);

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0]      pclk_sync_q, href_sync_q, vsync_sync_q;
  logic [SYNC_STAGES-1:0][7:0] d_sync_q;
  logic                        pclk_prev_q, vsync_prev_q;
  logic                        pclk_s, href_s, vsync_s;
  logic [7:0]                  d_s;
  logic                        strobe, vsync_rise, vsync_fall;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      pclk_sync_q  <= '0;
      href_sync_q  <= '0;
      vsync_sync_q <= '0;
      d_sync_q     <= '0;
      pclk_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      pclk_sync_q  <= {pclk_sync_q[SYNC_STAGES-2:0], cam_pclk};
      href_sync_q  <= {href_sync_q[SYNC_STAGES-2:0], cam_href};
      vsync_sync_q <= {vsync_sync_q[SYNC_STAGES-2:0], cam_vsync};
      d_sync_q     <= {d_sync_q[SYNC_STAGES-2:0], cam_d};
      pclk_prev_q  <= pclk_s;
      // VSYNC history advances only on PCLK strobes so its edges line up with strobes.
      if (strobe) vsync_prev_q <= vsync_s;
    end
  end

  assign pclk_s     = pclk_sync_q[SYNC_STAGES-1];
  assign href_s     = href_sync_q[SYNC_STAGES-1];
  assign vsync_s    = vsync_sync_q[SYNC_STAGES-1];
  assign d_s        = d_sync_q[SYNC_STAGES-1];
  assign strobe     = pclk_s && !pclk_prev_q;
  assign vsync_rise = strobe && vsync_s && !vsync_prev_q;
  assign vsync_fall = strobe && !vsync_s && vsync_prev_q;

  // ---------------- state ----------------
  cap_state_e    state_q, state_d;
  capture_mode_e mode_q, mode_d;
  logic          phase_q, phase_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic          first_px_q, first_px_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [CNT_W-1:0] line_width_q, line_width_d, line_count_q, line_count_d;
  logic          overflow_q, overflow_d, line_err_q, line_err_d;

  // FIFO interface
  pixel_t                    push_pix, head_pix;
  logic                      push, pop;
  logic                      fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // byte capture helpers set by the FSM
  logic             cap_en;
  logic [CNT_W-1:0] x_base;
  logic             phase_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    phase_d       = phase_q;
    byte0_d       = byte0_q;
    x_d           = x_q;
    y_d           = y_q;
    first_px_d    = first_px_q;
    frame_count_d = frame_count_q;
    line_width_d  = line_width_q;
    line_count_d  = line_count_q;
    overflow_d    = overflow_q;
    line_err_d    = line_err_q;
    push          = 1'b0;
    push_pix      = '0;
    cap_en        = 1'b0;
    x_base        = x_q;
    phase_base    = phase_q;

    if (clr_overflow) begin
      overflow_d = 1'b0;
      line_err_d = 1'b0;
    end

    if (!enable) begin
      // Abandon whatever was in progress; stats stay as they were.
      state_d = S_WAIT;
      phase_d = 1'b0;
    end else if (strobe) begin
      if (vsync_rise) begin
        state_d = S_WAIT;
        if (state_q != S_WAIT && y_q != '0) begin
          frame_count_d = frame_count_q + 16'd1;
          line_count_d  = y_q;
        end
      end else begin
        case (state_q)
          S_WAIT: begin
            if (vsync_fall) begin
              state_d    = S_FRAME;
              mode_d     = decode_mode(mode);
              y_d        = '0;
              first_px_d = 1'b1;
              phase_d    = 1'b0;
            end
          end
          S_FRAME: begin
            if (href_s) begin
              state_d    = S_LINE;
              cap_en     = 1'b1;
              x_base     = '0;
              phase_base = 1'b0;
            end
          end
          S_LINE: begin
            if (href_s) begin
              cap_en = 1'b1;
            end else begin
              state_d      = S_FRAME;
              line_width_d = x_q;
              y_d          = sat_inc(y_q);
              // A half-assembled pixel at line end is discarded.
              if (phase_q) line_err_d = 1'b1;
              phase_d      = 1'b0;
            end
          end
          default: state_d = S_WAIT;
        endcase
      end
    end

    if (cap_en) begin
      if (mode_q == MODE_RAW8 || phase_base) begin
        push          = 1'b1;
        push_pix.data = (mode_q == MODE_RAW8) ? {8'h00, d_s} : pack_pair(mode_q, byte0_q, d_s);
        push_pix.sof  = first_px_q;
        push_pix.sol  = (x_base == '0);
        x_d           = sat_inc(x_base);
        first_px_d    = 1'b0;
        phase_d       = 1'b0;
      end else begin
        byte0_d = d_s;
        phase_d = 1'b1;
        x_d     = x_base;
      end
    end

    // A dropped pixel still counted in x; set beats a coincident clear.
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q       <= S_WAIT;
      mode_q        <= MODE_RGB444;
      phase_q       <= 1'b0;
      byte0_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      first_px_q    <= 1'b0;
      frame_count_q <= '0;
      line_width_q  <= '0;
      line_count_q  <= '0;
      overflow_q    <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      phase_q       <= phase_d;
      byte0_q       <= byte0_d;
      x_q           <= x_d;
      y_q           <= y_d;
      first_px_q    <= first_px_d;
      frame_count_q <= frame_count_d;
      line_width_q  <= line_width_d;
      line_count_q  <= line_count_d;
      overflow_q    <= overflow_d;
      line_err_q    <= line_err_d;
    end
  end

  // ---------------- output FIFO ----------------
  sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_   (reset_),
    .wr_en_i  (push),
    .wr_dat_i (push_pix),
    .rd_en_i  (pop),
    .rd_dat_o (head_pix),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign pop       = pix_ready && !fifo_empty;
  assign pix_valid = (fifo_count != '0);
  // Head is masked while empty so the stream outputs read zero after reset.
  assign pix_data  = pix_valid ? head_pix.data : 16'h0000;
  assign pix_sof   = pix_valid && head_pix.sof;
  assign pix_sol   = pix_valid && head_pix.sol;

  assign frame_count = frame_count_q;
  assign line_width  = line_width_q;
  assign line_count  = line_count_q;
  assign overflow    = overflow_q;
  assign line_err    = line_err_q;
  assign busy        = (state_q != S_WAIT);

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench for ov7670_pixel_capture: camera waveform tasks, popped-pixel log, immediate-assert checks.
// Latency: camera PCLK runs at clk/4.
// Backpressure: pix_ready driven per step.
module tb_ov7670_pixel_capture;

  logic        clk = 1'b0;
  logic        reset_, enable, clr_overflow;
  logic [1:0]  mode;
  logic        cam_pclk, cam_href, cam_vsync;
  logic [7:0]  cam_d;
  logic [15:0] pix_data;
  logic        pix_sof, pix_sol, pix_valid, pix_ready;
  logic [15:0] frame_count;
  logic [10:0] line_width, line_count;
  logic        overflow, line_err, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] cap_data [$];
  logic        cap_sof  [$];
  logic        cap_sol  [$];

  always #5 clk = ~clk;

  ov7670_pixel_capture dut (
    .clk          (clk),
    .reset_       (reset_),
    .enable       (enable),
    .mode         (mode),
    .clr_overflow (clr_overflow),
    .cam_pclk     (cam_pclk),
    .cam_href     (cam_href),
    .cam_vsync    (cam_vsync),
    .cam_d        (cam_d),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .pix_sol      (pix_sol),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .frame_count  (frame_count),
    .line_width   (line_width),
    .line_count   (line_count),
    .overflow     (overflow),
    .line_err     (line_err),
    .busy         (busy)
  );

  // Log every accepted pixel, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_ && pix_valid && pix_ready) begin
      cap_data.push_back(pix_data);
      cap_sof.push_back(pix_sof);
      cap_sol.push_back(pix_sol);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cam_cycle(input logic href, input logic vs, input logic [7:0] d);
    cam_href  = href;
    cam_vsync = vs;
    cam_d     = d;
    cam_pclk  = 1'b0;
    tick(); tick();
    cam_pclk  = 1'b1;
    tick(); tick();
  endtask

  task automatic frame_start();
    cam_cycle(1'b0, 1'b1, 8'h00);
    cam_cycle(1'b0, 1'b1, 8'h00);
    cam_cycle(1'b0, 1'b0, 8'h00);
    cam_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end();
    cam_cycle(1'b0, 1'b1, 8'h00);
    cam_cycle(1'b0, 1'b1, 8'h00);
  endtask

  // n bytes: incrementing from b0 when inc, else alternating b0,b1; then two idle PCLKs.
  task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1, input bit inc);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = inc ? b0 + 8'(i) : (((i % 2) == 1) ? b1 : b0);
      cam_cycle(1'b1, 1'b0, d);
    end
    cam_cycle(1'b0, 1'b0, 8'h00);
    cam_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_log();
    cap_data.delete();
    cap_sof.delete();
    cap_sol.delete();
  endtask

  initial begin
    reset_ = 1'b0; enable = 1'b0; mode = 2'd0; clr_overflow = 1'b0;
    cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0; cam_d = 8'h00;
    pix_ready = 1'b1;
    tick(); tick(); tick();

    // ---- reset state ----
    check("rst_valid", pix_valid, 1'b0);
    check("rst_data", pix_data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_frames", frame_count, 16'd0);
    check("rst_lw", line_width, 11'd0);
    check("rst_lc", line_count, 11'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_lerr", line_err, 1'b0);
    reset_ = 1'b1;
    enable = 1'b1;
    tick();

    // ---- 1: RGB565, 4 lines x 4 pixels of F8,1F ----
    mode = 2'd1;
    frame_start();
    check("t1_busy", busy, 1'b1);
    for (int l = 0; l < 4; l++) send_line(8, 8'hF8, 8'h1F, 1'b0);
    frame_end();
    repeat (4) tick();
    check("t1_npix", cap_data.size(), 16);
    for (int i = 0; i < 16 && i < cap_data.size(); i++) begin
      check($sformatf("t1_data%0d", i), cap_data[i], 16'hF81F);
      check($sformatf("t1_sof%0d", i), cap_sof[i], (i == 0));
      check($sformatf("t1_sol%0d", i), cap_sol[i], ((i % 4) == 0));
    end
    check("t1_lw", line_width, 11'd4);
    check("t1_lc", line_count, 11'd4);
    check("t1_frames", frame_count, 16'd1);
    check("t1_idle", busy, 1'b0);
    clear_log();

    // ---- 2: RGB444 pair, then RAW8 line ----
    mode = 2'd0;
    frame_start();
    send_line(2, 8'h0A, 8'h5C, 1'b0);
    frame_end();
    mode = 2'd2;
    frame_start();
    send_line(4, 8'h10, 8'h00, 1'b1);
    frame_end();
    repeat (4) tick();
    check("t2_npix", cap_data.size(), 5);
    if (cap_data.size() == 5) begin
      check("t2_rgb444", cap_data[0], 16'h0A5C);
      check("t2_raw0", cap_data[1], 16'h0010);
      check("t2_raw1", cap_data[2], 16'h0011);
      check("t2_raw2", cap_data[3], 16'h0012);
      check("t2_raw3", cap_data[4], 16'h0013);
      check("t2_sof_raw", cap_sof[1], 1'b1);
      check("t2_sof_mid", cap_sof[2], 1'b0);
    end
    check("t2_frames", frame_count, 16'd3);
    check("t2_lw", line_width, 11'd4);
    check("t2_lc", line_count, 11'd1);
    clear_log();

    // ---- 3: backpressure, 20 RAW8 pixels into 16-deep FIFO ----
    pix_ready = 1'b0;
    frame_start();
    cam_href = 1'b1; cam_vsync = 1'b0; cam_d = 8'h00; cam_pclk = 1'b0;
    tick(); tick();
    cam_pclk = 1'b1;
    tick();
    check("t3_lat_k1", pix_valid, 1'b0);
    tick();
    check("t3_lat_push", pix_valid, 1'b0);
    tick();
    check("t3_lat_valid", pix_valid, 1'b1);
    for (int i = 1; i < 20; i++) cam_cycle(1'b1, 1'b0, 8'(i));
    cam_cycle(1'b0, 1'b0, 8'h00);
    cam_cycle(1'b0, 1'b0, 8'h00);
    check("t3_ovf", overflow, 1'b1);
    check("t3_valid", pix_valid, 1'b1);
    check("t3_head", pix_data, 16'h0000);
    check("t3_lw", line_width, 11'd20);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3_ovf_clr", overflow, 1'b0);
    pix_ready = 1'b1;
    repeat (20) tick();
    check("t3_npix", cap_data.size(), 16);
    for (int i = 0; i < 16 && i < cap_data.size(); i++)
      check($sformatf("t3_order%0d", i), cap_data[i], 16'(i));
    frame_end();
    check("t3_frames", frame_count, 16'd4);
    clear_log();

    // ---- 4: odd byte count in 2-byte mode ----
    mode = 2'd1;
    frame_start();
    send_line(7, 8'h01, 8'h00, 1'b1);
    check("t4_lerr", line_err, 1'b1);
    check("t4_lw", line_width, 11'd3);
    frame_end();
    repeat (4) tick();
    check("t4_npix", cap_data.size(), 3);
    if (cap_data.size() == 3) begin
      check("t4_p0", cap_data[0], 16'h0102);
      check("t4_p1", cap_data[1], 16'h0304);
      check("t4_p2", cap_data[2], 16'h0506);
    end
    check("t4_frames", frame_count, 16'd5);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t4_lerr_clr", line_err, 1'b0);
    clear_log();

    // ---- 5: enable dropped mid-line ----
    mode = 2'd2;
    frame_start();
    for (int i = 0; i < 3; i++) cam_cycle(1'b1, 1'b0, 8'hAA);
    check("t5_busy_on", busy, 1'b1);
    enable = 1'b0;
    tick();
    check("t5_busy_off", busy, 1'b0);
    cam_cycle(1'b0, 1'b0, 8'h00);
    frame_end();
    check("t5_frames", frame_count, 16'd5);
    check("t5_lc", line_count, 11'd1);
    enable = 1'b1;
    repeat (4) tick();
    clear_log();

    // ---- 6: mode change mid-frame, then reset mid-line ----
    mode = 2'd0;
    frame_start();
    send_line(2, 8'h0A, 8'h5C, 1'b0);
    mode = 2'd1;
    send_line(2, 8'hF8, 8'h1F, 1'b0);
    frame_end();
    check("t6_frames", frame_count, 16'd6);
    check("t6_lc", line_count, 11'd2);
    frame_start();
    send_line(2, 8'hF8, 8'h1F, 1'b0);
    repeat (4) tick();
    check("t6_npix", cap_data.size(), 3);
    if (cap_data.size() == 3) begin
      check("t6_old_mode0", cap_data[0], 16'h0A5C);
      check("t6_old_mode1", cap_data[1], 16'h081F);
      check("t6_new_mode", cap_data[2], 16'hF81F);
      check("t6_new_sof", cap_sof[2], 1'b1);
    end
    pix_ready = 1'b0;
    cam_cycle(1'b1, 1'b0, 8'h12);
    cam_cycle(1'b1, 1'b0, 8'h34);
    cam_cycle(1'b1, 1'b0, 8'h56);
    cam_cycle(1'b1, 1'b0, 8'h78);
    tick(); tick();
    check("t6_held", pix_valid, 1'b1);
    reset_ = 1'b0;
    tick();
    check("t6_rst_valid", pix_valid, 1'b0);
    check("t6_rst_frames", frame_count, 16'd0);
    check("t6_rst_lw", line_width, 11'd0);
    check("t6_rst_lc", line_count, 11'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_ovf", overflow, 1'b0);
    check("t6_rst_lerr", line_err, 1'b0);
    reset_ = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
